// File: rtl/nv_ram_rwsp_param_init_pkg.sv
// Shared definitions for the parametrised 1R1W RAM family: error flag indices,
// sweep FSM state type and the address-width helper.
package nv_ram_rwsp_param_init_pkg;

    localparam int NV_RAM_ERR_OOB  = 0;
    localparam int NV_RAM_ERR_INIT = 1;

    typedef enum logic [0:0] {
        ST_CLR = 1'b0,
        ST_RDY = 1'b1
    } init_state_e;

    // Address width for a given depth; never narrower than one bit.
    function automatic int nv_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/nv_ram_rwsp_param_init_seq.sv
// Post-reset clear sequencer: walks every word once writing INIT_VAL,
// then raises init_done and stays ready until the next reset.
module nv_ram_rwsp_param_init_seq
    import nv_ram_rwsp_param_init_pkg::*;
#(
    parameter int               DEPTH    = 61,
    parameter int               WIDTH    = 65,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    parameter int               AW       = nv_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             sweep_we,
    output logic [AW-1:0]    sweep_addr,
    output logic [WIDTH-1:0] sweep_data,
    output logic             init_done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    init_state_e   state_r;
    init_state_e   state_s;
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] cnt_s;
    logic          init_done_r;

    // Next-state logic: advance the sweep counter until the last word is cleared.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_CLR: begin
                if (cnt_r == LAST_ADDR) begin
                    state_s = ST_RDY;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_RDY: begin
                state_s = ST_RDY;
            end
            default: begin
                state_s = ST_CLR;
                cnt_s   = '0;
            end
        endcase
    end

    // State, counter and init_done registers; any reset cycle restarts the sweep.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_CLR;
            cnt_r       <= '0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            init_done_r <= (state_s == ST_RDY);
        end
    end

    assign sweep_we   = (state_r == ST_CLR);
    assign sweep_addr = cnt_r;
    assign sweep_data = INIT_VAL;
    assign init_done  = init_done_r;

endmodule

// File: rtl/nv_ram_rwsp_param_init.sv
// Parametrised 1R1W flop-array RAM with registered read address, ore-gated
// output register, post-reset clear sweep, write bypass and sticky error flags.
module nv_ram_rwsp_param_init
    import nv_ram_rwsp_param_init_pkg::*;
#(
    parameter int               DEPTH    = 61,
    parameter int               WIDTH    = 65,
    parameter bit               BYPASS   = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    localparam int              AW       = nv_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    input  logic [31:0]      pwrbus_ram_pd,
    output logic             init_done,
    output logic [1:0]       err
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];

    logic             sweep_we_s;
    logic [AW-1:0]    sweep_addr_s;
    logic [WIDTH-1:0] sweep_data_s;
    logic             init_done_s;

    logic [AW-1:0]    ra_d_r;
    logic             rd_pend_r;
    logic [WIDTH-1:0] dout_r;
    logic             dout_vld_r;
    logic [1:0]       err_r;

    logic             wa_ok_s;
    logic             ra_ok_s;
    logic             ra_d_ok_s;
    logic             usr_we_s;
    logic             usr_re_s;
    logic             wr_en_s;
    logic [AW-1:0]    wr_addr_s;
    logic [WIDTH-1:0] wr_data_s;
    logic [WIDTH-1:0] rd_data_s;
    logic             unused_pwr_s;

    assign unused_pwr_s = ^pwrbus_ram_pd;

    nv_ram_rwsp_param_init_seq #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .INIT_VAL (INIT_VAL),
        .AW       (AW)
    ) u_init_seq (
        .clk        (clk),
        .rstn       (rstn),
        .sweep_we   (sweep_we_s),
        .sweep_addr (sweep_addr_s),
        .sweep_data (sweep_data_s),
        .init_done  (init_done_s)
    );

    // Range checks, write-port mux (sweep owns the port until ready) and read-data select.
    always_comb begin
        wa_ok_s   = ({1'b0, wa} < DEPTH_W);
        ra_ok_s   = ({1'b0, ra} < DEPTH_W);
        ra_d_ok_s = ({1'b0, ra_d_r} < DEPTH_W);
        usr_we_s  = init_done_s && we && wa_ok_s;
        usr_re_s  = init_done_s && re;
        if (sweep_we_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = sweep_addr_s;
            wr_data_s = sweep_data_s;
        end else begin
            wr_en_s   = usr_we_s;
            wr_addr_s = wa;
            wr_data_s = di;
        end
        // Out-of-range read addresses return the clear value instead of array data.
        if (BYPASS && usr_we_s && (wa == ra_d_r)) begin
            rd_data_s = di;
        end else if (ra_d_ok_s) begin
            rd_data_s = mem_r[ra_d_r];
        end else begin
            rd_data_s = INIT_VAL;
        end
    end

    // Array write port; held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (rstn && wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Read-address stage, output register and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ra_d_r     <= '0;
            rd_pend_r  <= 1'b0;
            dout_r     <= '0;
            dout_vld_r <= 1'b0;
            err_r      <= 2'b00;
        end else begin
            if (ore) begin
                dout_r     <= rd_data_s;
                dout_vld_r <= rd_pend_r;
            end
            if (usr_re_s) begin
                ra_d_r    <= ra;
                rd_pend_r <= 1'b1;
            end else if (ore) begin
                rd_pend_r <= 1'b0;
            end
            if (!init_done_s && (we || re)) begin
                err_r[NV_RAM_ERR_INIT] <= 1'b1;
            end
            if (init_done_s && ((we && !wa_ok_s) || (re && !ra_ok_s))) begin
                err_r[NV_RAM_ERR_OOB] <= 1'b1;
            end
        end
    end

    assign dout      = dout_r;
    assign dout_vld  = dout_vld_r;
    assign init_done = init_done_s;
    assign err       = err_r;

endmodule

// File: tb/tb_nv_ram_rwsp_param_init.sv
// Directed bench for nv_ram_rwsp_param_init (DEPTH=61, WIDTH=65, BYPASS=1):
// a cycle-level reference model checked every cycle plus hand-computed expectations.
module tb_nv_ram_rwsp_param_init;

    localparam int DEPTH = 61;
    localparam int WIDTH = 65;
    localparam int AW    = 6;
    localparam logic [WIDTH-1:0] INIT = '0;

    logic             clk = 1'b0;
    logic             rstn;
    logic [AW-1:0]    ra;
    logic             re;
    logic             ore;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [AW-1:0]    wa;
    logic             we;
    logic [WIDTH-1:0] di;
    logic [31:0]      pwr;
    logic             init_done;
    logic [1:0]       err;

    int n_vec = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    nv_ram_rwsp_param_init #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .BYPASS   (1'b1),
        .INIT_VAL (INIT)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .ra            (ra),
        .re            (re),
        .ore           (ore),
        .dout          (dout),
        .dout_vld      (dout_vld),
        .wa            (wa),
        .we            (we),
        .di            (di),
        .pwrbus_ram_pd (pwr),
        .init_done     (init_done),
        .err           (err)
    );

    // Reference model: memory as an array, readiness as "cycles since release >= DEPTH".
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic [AW-1:0]    m_ra_d;
    logic             m_pend;
    logic [WIDTH-1:0] m_dout;
    logic             m_vld;
    logic [1:0]       m_err;
    int               m_rel = 0;
    logic             m_ready;

    assign m_ready = (m_rel >= DEPTH);

    always @(posedge clk) begin
        if (!rstn) begin
            m_rel  <= 0;
            m_ra_d <= '0;
            m_pend <= 1'b0;
            m_dout <= '0;
            m_vld  <= 1'b0;
            m_err  <= 2'b00;
        end else begin
            if (m_rel < 1000) m_rel <= m_rel + 1;
            if (!m_ready) begin
                m_mem[m_rel] <= INIT;
                if (we || re) m_err[1] <= 1'b1;
            end else begin
                if (we) begin
                    if (int'(wa) < DEPTH) m_mem[wa] <= di;
                    else m_err[0] <= 1'b1;
                end
                if (re) begin
                    m_ra_d <= ra;
                    m_pend <= 1'b1;
                    if (int'(ra) >= DEPTH) m_err[0] <= 1'b1;
                end
            end
            if (ore) begin
                if (m_ready && we && int'(wa) < DEPTH && wa == m_ra_d) m_dout <= di;
                else if (int'(m_ra_d) < DEPTH) m_dout <= m_mem[m_ra_d];
                else m_dout <= INIT;
                m_vld <= m_pend;
                if (!(m_ready && re)) m_pend <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checking) begin
            check("model_dout", dout, m_dout);
            check("model_dout_vld", WIDTH'(dout_vld), WIDTH'(m_vld));
            check("model_init_done", WIDTH'(init_done), WIDTH'(m_ready));
            check("model_err", WIDTH'(err), WIDTH'(m_err));
        end
    end

    task automatic wait_init(input string name, input int start, input int exp);
        int cycles;
        cycles = start;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (init_done === 1'b1) break;
        end
        check(name, WIDTH'(cycles), WIDTH'(exp));
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        we = 1'b1; wa = a; di = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [WIDTH-1:0] exp, input string name);
        re = 1'b1; ra = a;
        @(negedge clk);
        re = 1'b0; ore = 1'b1;
        @(negedge clk);
        ore = 1'b0;
        check(name, dout, exp);
        check({name, "_vld"}, WIDTH'(dout_vld), WIDTH'(1'b1));
    endtask

    localparam logic [WIDTH-1:0] V = 65'h1_2345_6789_ABCD_EF01;
    localparam logic [WIDTH-1:0] A = 65'h0_AAAA_5555_AAAA_5555;
    localparam logic [WIDTH-1:0] B = 65'h1_BBBB_CCCC_DDDD_EEEE;
    localparam logic [WIDTH-1:0] C = 65'h0_0000_C0DE_0000_0045;

    initial begin
        rstn = 1'b0; re = 1'b0; ore = 1'b0; we = 1'b0;
        ra = '0; wa = '0; di = '0; pwr = 32'h0;
        @(posedge clk);
        #1 checking = 1'b1;
        @(negedge clk);
        check("rst_dout", dout, INIT);
        check("rst_dout_vld", WIDTH'(dout_vld), WIDTH'(1'b0));
        check("rst_init_done", WIDTH'(init_done), WIDTH'(1'b0));
        check("rst_err", WIDTH'(err), WIDTH'(2'b00));
        rstn = 1'b1;

        // Sweep length, then every word reads back cleared.
        wait_init("t1_init_cycles", 0, 61);
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i), INIT, "t1_read");

        // Plain write then read.
        do_write(6'd5, V);
        do_read(6'd5, V, "t3_read");

        // Write on the ore edge to ra_d is forwarded.
        do_write(6'd7, A);
        re = 1'b1; ra = 6'd7;
        @(negedge clk);
        re = 1'b0; ore = 1'b1; we = 1'b1; wa = 6'd7; di = B;
        @(negedge clk);
        ore = 1'b0; we = 1'b0;
        check("t4_bypass", dout, B);
        do_read(6'd7, B, "t4_after");

        // Out-of-range write and read.
        do_write(6'd61, {WIDTH{1'b1}});
        re = 1'b1; ra = 6'd63;
        @(negedge clk);
        re = 1'b0; ore = 1'b1;
        @(negedge clk);
        ore = 1'b0;
        check("t5_err", WIDTH'(err), WIDTH'(2'b01));
        check("t5_dout", dout, INIT);
        do_read(6'd5, V, "t5_word5");
        do_read(6'd60, INIT, "t5_word60");

        // ore held off: output holds, then data, then a stale ore clears vld.
        re = 1'b1; ra = 6'd5;
        @(negedge clk);
        re = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t6_hold_dout", dout, INIT);
            check("t6_hold_vld", WIDTH'(dout_vld), WIDTH'(1'b1));
            @(negedge clk);
        end
        ore = 1'b1;
        @(negedge clk);
        check("t6_data", dout, V);
        check("t6_data_vld", WIDTH'(dout_vld), WIDTH'(1'b1));
        @(negedge clk);
        ore = 1'b0;
        check("t6_second_vld", WIDTH'(dout_vld), WIDTH'(1'b0));

        // Reset pulsed mid-sweep; accesses during the sweep are dropped.
        do_write(6'd45, C);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        we = 1'b1; wa = 6'd3; di = C; re = 1'b1; ra = 6'd9;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        wait_init("t2_init_cycles", 11, 61);
        check("t2_err", WIDTH'(err), WIDTH'(2'b10));
        do_read(6'd45, INIT, "t2_word45");
        do_read(6'd3, INIT, "t2_word3");

        repeat (2) @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
